// File: rtl/fetch_if_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Data is returned in the same cycle that imem_ready is asserted.
interface fetch_if_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_if.sv
// Instruction fetch stage: owns the PC, the IF/ID register and the exception PC,
// and arbitrates execute redirects, decode control feedback and memory wait states.
module fetch_if #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002,
  parameter logic [15:0] NOP_INST   = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_p1,
  input  logic               redirect_ixif_p1,
  input  logic        [15:0] redirect_pc_ixif_p1,
  input  logic               halt_idif_p1,
  input  logic               illegal_op_idif_p1,
  input  logic               return_execution_idif_p1,
  input  logic               jmp_displacement_idif_p1,
  input  logic signed [15:0] jmp_displacement_value_idif_p1,
  fetch_if_if.master         imem,
  output logic        [15:0] inst_ifid_p1,
  output logic        [15:0] pc_p1,
  output logic        [15:0] epc_p1,
  output logic               inst_valid_ifid_p1,
  output logic               halted_p1
);

  typedef enum logic [1:0] {FETCH, WAIT_MEM, HALTED} state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic        req_q;

  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic [15:0] pc_rel(input logic [15:0] base,
                                         input logic signed [15:0] disp);
    return base + $unsigned(disp);
  endfunction

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;

  // IF -> ID stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= FETCH;
      req_q              <= 1'b1;
      pc_q               <= RESET_PC;
      inst_ifid_p1       <= NOP_INST;
      inst_valid_ifid_p1 <= 1'b0;
      pc_p1              <= 16'h0000;
      epc_p1             <= 16'h0000;
      halted_p1          <= 1'b0;
    end else begin
      case (state_q)
        HALTED: begin
          // Only reset leaves HALTED; everything is frozen.
        end
        default: begin
          if (redirect_ixif_p1) begin
            // Execute redirect wins over stall and drops any pending fetch.
            pc_q               <= redirect_pc_ixif_p1;
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
            state_q            <= FETCH;
          end else if (stall_p1) begin
            state_q <= state_q;
          end else if (inst_valid_ifid_p1 && illegal_op_idif_p1) begin
            epc_p1             <= pc_p1;
            pc_q               <= EXC_VECTOR;
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
            state_q            <= FETCH;
          end else if (inst_valid_ifid_p1 && return_execution_idif_p1) begin
            pc_q               <= epc_p1;
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
            state_q            <= FETCH;
          end else if (inst_valid_ifid_p1 && jmp_displacement_idif_p1) begin
            pc_q               <= pc_rel(pc_p1, jmp_displacement_value_idif_p1);
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
            state_q            <= FETCH;
          end else if (inst_valid_ifid_p1 && halt_idif_p1) begin
            state_q            <= HALTED;
            req_q              <= 1'b0;
            halted_p1          <= 1'b1;
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
          end else if (imem.imem_ready) begin
            inst_ifid_p1       <= imem.imem_rdata;
            inst_valid_ifid_p1 <= 1'b1;
            pc_p1              <= pc_inc(pc_q);
            pc_q               <= pc_inc(pc_q);
            state_q            <= FETCH;
          end else begin
            inst_ifid_p1       <= NOP_INST;
            inst_valid_ifid_p1 <= 1'b0;
            state_q            <= WAIT_MEM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_if.sv
// Scenario bench for fetch_if: each row drives one cycle of stimulus and queues
// the full expected output snapshot, which is popped and compared after the edge.
module tb_fetch_if;

  typedef logic [66:0] snap_t;

  typedef struct {
    logic        rst, stall, redir;
    logic [15:0] rpc;
    logic        ill, ret, jmp, halt;
    logic [15:0] disp;
    logic        ready;
    logic [15:0] rdata;
    snap_t       exp;
  } row_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_p1 = 1'b0;
  logic        redirect_ixif_p1 = 1'b0;
  logic [15:0] redirect_pc_ixif_p1 = '0;
  logic        halt_idif_p1 = 1'b0;
  logic        illegal_op_idif_p1 = 1'b0;
  logic        return_execution_idif_p1 = 1'b0;
  logic        jmp_displacement_idif_p1 = 1'b0;
  logic signed [15:0] jmp_displacement_value_idif_p1 = '0;
  logic [15:0] inst_ifid_p1, pc_p1, epc_p1;
  logic        inst_valid_ifid_p1, halted_p1;

  int n_cmp  = 0;
  int n_fail = 0;
  snap_t exp_q[$];

  fetch_if_if bus ();

  fetch_if dut (
    .clk                            (clk),
    .rst                            (rst),
    .stall_p1                       (stall_p1),
    .redirect_ixif_p1               (redirect_ixif_p1),
    .redirect_pc_ixif_p1            (redirect_pc_ixif_p1),
    .halt_idif_p1                   (halt_idif_p1),
    .illegal_op_idif_p1             (illegal_op_idif_p1),
    .return_execution_idif_p1       (return_execution_idif_p1),
    .jmp_displacement_idif_p1       (jmp_displacement_idif_p1),
    .jmp_displacement_value_idif_p1 (jmp_displacement_value_idif_p1),
    .imem                           (bus),
    .inst_ifid_p1                   (inst_ifid_p1),
    .pc_p1                          (pc_p1),
    .epc_p1                         (epc_p1),
    .inst_valid_ifid_p1             (inst_valid_ifid_p1),
    .halted_p1                      (halted_p1)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic req, input logic [15:0] addr,
                               input logic [15:0] inst, input logic [15:0] pc,
                               input logic v, input logic h, input logic [15:0] epc);
    return {req, addr, inst, pc, v, h, epc};
  endfunction

  function automatic row_t R(input logic r, input logic st, input logic rd,
                             input logic [15:0] rpc, input logic ill, input logic ret,
                             input logic jmp, input logic hlt, input logic [15:0] disp,
                             input logic rdy, input logic [15:0] rdata, input snap_t exp);
    row_t x;
    x.rst = r; x.stall = st; x.redir = rd; x.rpc = rpc;
    x.ill = ill; x.ret = ret; x.jmp = jmp; x.halt = hlt; x.disp = disp;
    x.ready = rdy; x.rdata = rdata; x.exp = exp;
    return x;
  endfunction

  function automatic snap_t snap();
    return {bus.imem_req, bus.imem_addr, inst_ifid_p1, pc_p1,
            inst_valid_ifid_p1, halted_p1, epc_p1};
  endfunction

  task automatic drive_row(input row_t r);
    rst = r.rst; stall_p1 = r.stall;
    redirect_ixif_p1 = r.redir; redirect_pc_ixif_p1 = r.rpc;
    illegal_op_idif_p1 = r.ill; return_execution_idif_p1 = r.ret;
    jmp_displacement_idif_p1 = r.jmp; halt_idif_p1 = r.halt;
    jmp_displacement_value_idif_p1 = r.disp;
    bus.imem_ready = r.ready; bus.imem_rdata = r.rdata;
    exp_q.push_back(r.exp);
  endtask

  task automatic test_reset();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(1,0,0,16'h0,0,0,0,0,16'h0,1,16'hAAAA, mk(1,16'h0,16'h0800,16'h0,0,0,16'h0)));
    rows.push_back(R(1,0,0,16'h0,1,0,0,1,16'h0,0,16'hAAAA, mk(1,16'h0,16'h0800,16'h0,0,0,16'h0)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL reset[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_sequential();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h4000, mk(1,16'h2,16'h4000,16'h2,1,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h4100, mk(1,16'h4,16'h4100,16'h4,1,0,16'h0)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL sequential[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_wait_mem();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,0,16'hDEAD, mk(1,16'h4,16'h0800,16'h4,0,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,0,16'hDEAD, mk(1,16'h4,16'h0800,16'h4,0,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h4200, mk(1,16'h6,16'h4200,16'h6,1,0,16'h0)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL wait_mem[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_jmp();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,0,1,16'h000E,0,0,0,0,16'h0,1,16'hBEEF, mk(1,16'h000E,16'h0800,16'h6,0,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h1234, mk(1,16'h0010,16'h1234,16'h0010,1,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,1,0,16'hFFF0,1,16'h5555, mk(1,16'h0000,16'h0800,16'h0010,0,0,16'h0)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL jmp[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_exception();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,0,1,16'h001E,0,0,0,0,16'h0,1,16'h6666, mk(1,16'h001E,16'h0800,16'h0010,0,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h2222, mk(1,16'h0020,16'h2222,16'h0020,1,0,16'h0)));
    rows.push_back(R(0,0,0,16'h0,1,0,1,0,16'h0040,1,16'h6666, mk(1,16'h0002,16'h0800,16'h0020,0,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h3333, mk(1,16'h0004,16'h3333,16'h0004,1,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,1,0,1,16'h0,1,16'h6666, mk(1,16'h0020,16'h0800,16'h0004,0,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h4444, mk(1,16'h0022,16'h4444,16'h0022,1,0,16'h0020)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL exception[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,1,0,16'h0,1,0,0,0,16'h0,1,16'h7777, mk(1,16'h0022,16'h4444,16'h0022,1,0,16'h0020)));
    rows.push_back(R(0,1,0,16'h0,0,0,1,1,16'h0,1,16'h7777, mk(1,16'h0022,16'h4444,16'h0022,1,0,16'h0020)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL stall[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_redirect();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,1,1,16'h0100,0,0,0,0,16'h0,1,16'h7777, mk(1,16'h0100,16'h0800,16'h0022,0,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,0,16'h7777, mk(1,16'h0100,16'h0800,16'h0022,0,0,16'h0020)));
    rows.push_back(R(0,0,1,16'h0200,0,0,0,0,16'h0,1,16'h7777, mk(1,16'h0200,16'h0800,16'h0022,0,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h8888, mk(1,16'h0202,16'h8888,16'h0202,1,0,16'h0020)));
    rows.push_back(R(0,0,1,16'hFFFE,0,0,0,0,16'h0,1,16'h7777, mk(1,16'hFFFE,16'h0800,16'h0202,0,0,16'h0020)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h0101, mk(1,16'h0000,16'h0101,16'h0000,1,0,16'h0020)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL redirect[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_halt();
    row_t rows[$];
    snap_t got, exp;
    rows.push_back(R(0,0,0,16'h0,0,0,0,1,16'h0,1,16'h9999, mk(0,16'h0000,16'h0800,16'h0000,0,1,16'h0020)));
    for (int k = 0; k < 10; k++)
      rows.push_back(R(0,0,1,16'h0300,1,0,0,0,16'h0,1,16'h9999, mk(0,16'h0000,16'h0800,16'h0000,0,1,16'h0020)));
    rows.push_back(R(1,0,0,16'h0,0,0,0,0,16'h0,1,16'h9999, mk(1,16'h0000,16'h0800,16'h0000,0,0,16'h0000)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,1,16'h4000, mk(1,16'h0002,16'h4000,16'h0002,1,0,16'h0000)));
    rows.push_back(R(0,0,0,16'h0,0,0,0,0,16'h0,0,16'h4000, mk(1,16'h0002,16'h0800,16'h0002,0,0,16'h0000)));
    rows.push_back(R(1,0,0,16'h0,0,0,0,0,16'h0,1,16'h4000, mk(1,16'h0000,16'h0800,16'h0000,0,0,16'h0000)));
    foreach (rows[i]) begin
      drive_row(rows[i]); @(posedge clk); #1;
      got = snap(); exp = exp_q.pop_front(); n_cmp++;
      if (got !== exp) begin n_fail++; $display("FAIL halt[%0d] got=%h exp=%h", i, got, exp); end
    end
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = '0;
    test_reset();
    test_sequential();
    test_wait_mem();
    test_jmp();
    test_exception();
    test_stall();
    test_redirect();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
